// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Definitions shared by the RV32I 5-stage pipeline blocks (decode,
// id_ex_stage, forwarding_unit, ex_mem_stage):
//   - ctrl_t    : packed decoded-control bundle carried down the pipe
//   - CTRL_NOP  : control value of a bubble (no register/memory side effects)
//   - aluop_e / wbsel_e : ALU operation and write-back source encodings
//   - DEFAULT_* : default datapath widths
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int DEFAULT_XLEN   = 32;
    localparam int DEFAULT_REG_AW = 5;
    localparam int DEFAULT_CNT_W  = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } aluop_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wbsel_e;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   branch;
        logic   jump;
        logic   alusrc;
        aluop_e aluop;
        wbsel_e wbsel;
    } ctrl_t;

    // A bubble must never write the register file or touch memory.
    localparam ctrl_t CTRL_NOP = '{
        regwrite: 1'b0,
        memread:  1'b0,
        memwrite: 1'b0,
        branch:   1'b0,
        jump:     1'b0,
        alusrc:   1'b0,
        aluop:    ALU_ADD,
        wbsel:    WB_ALU
    };

endpackage : pipeline_pkg

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector. Asserts lu when the
// instruction in EX is a load whose destination is read by the instruction
// in Decode. x0 never creates a hazard, and only operands the Decode
// instruction actually reads are compared.
// Ports:
//   validE, memreadE, rdE        : EX-stage instruction state
//   validD, rs1D, rs2D,
//   use_rs1D, use_rs2D           : Decode-stage source operands
//   lu                           : load-use hazard present
// -----------------------------------------------------------------------------
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              validE,
    input  logic              memreadE,
    input  logic [REG_AW-1:0] rdE,
    input  logic              validD,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic              use_rs1D,
    input  logic              use_rs2D,
    output logic              lu
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1 = use_rs1D && (rs1D == rdE);
    assign hit_rs2 = use_rs2D && (rs2D == rdE);

    assign lu = validE && memreadE && (rdE != '0) && validD && (hit_rs1 || hit_rs2);

endmodule : load_use_detect

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID->EX pipeline register of the RV32I 5-stage pipeline with integrated
// load-use hazard handling.
//   - Registers Decode operands/control into the EX-side fields.
//   - Inserts a bubble on a taken branch/jump or a load-use hazard.
//   - Freezes completely while the data memory stalls.
//   - Drives stallF/stallD (hold PC and IF/ID) and flushD (clear IF/ID).
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   validD, rs1D/rs2D/rdD,
//   use_rs1D/use_rs2D, ctrlD,
//   rd1D/rd2D/immD/pcD             : Decode-stage instruction
//   branch_takenE, stall_mem       : pipeline control from EX / MEM
//   validE, rs1E/rs2E/rdE, ctrlE,
//   rd1E/rd2E/immE/pcE             : registered EX-stage instruction
//   stallF, stallD, flushD         : front-end hazard controls
// Optional feature (macro ID_EX_PERF_CNT_EN):
//   lu_stall_cnt, flush_cnt        : saturating performance counters
// -----------------------------------------------------------------------------
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
`ifdef ID_EX_PERF_CNT_EN
    parameter int CNT_W  = DEFAULT_CNT_W,
`endif
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    // Decode side
    input  logic              validD,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rdD,
    input  logic              use_rs1D,
    input  logic              use_rs2D,
    input  ctrl_t             ctrlD,
    input  logic [XLEN-1:0]   rd1D,
    input  logic [XLEN-1:0]   rd2D,
    input  logic [XLEN-1:0]   immD,
    input  logic [XLEN-1:0]   pcD,
    // Pipeline control
    input  logic              branch_takenE,
    input  logic              stall_mem,
    // EX side
    output logic              validE,
    output logic [REG_AW-1:0] rs1E,
    output logic [REG_AW-1:0] rs2E,
    output logic [REG_AW-1:0] rdE,
    output ctrl_t             ctrlE,
    output logic [XLEN-1:0]   rd1E,
    output logic [XLEN-1:0]   rd2E,
    output logic [XLEN-1:0]   immE,
    output logic [XLEN-1:0]   pcE,
    // Hazard outputs
    output logic              stallF,
    output logic              stallD,
    output logic              flushD
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  lu_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic              valid_q, valid_d;
    logic [REG_AW-1:0] rs1_q,   rs1_d;
    logic [REG_AW-1:0] rs2_q,   rs2_d;
    logic [REG_AW-1:0] rd_q,    rd_d;
    ctrl_t             ctrl_q,  ctrl_d;
    logic [XLEN-1:0]   rd1_q,   rd1_d;
    logic [XLEN-1:0]   rd2_q,   rd2_d;
    logic [XLEN-1:0]   imm_q,   imm_d;
    logic [XLEN-1:0]   pc_q,    pc_d;

    logic lu;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .validE   (valid_q),
        .memreadE (ctrl_q.memread),
        .rdE      (rd_q),
        .validD   (validD),
        .rs1D     (rs1D),
        .rs2D     (rs2D),
        .use_rs1D (use_rs1D),
        .use_rs2D (use_rs2D),
        .lu       (lu)
    );

    // Next-state selection: memory stall holds, then branch/load-use bubble,
    // otherwise capture Decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch;
        // the defaults here are "hold", which is exactly the stall_mem case.
        valid_d = valid_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;

        if (!stall_mem) begin
            if (branch_takenE || lu) begin
                valid_d = 1'b0;
                rs1_d   = '0;
                rs2_d   = '0;
                rd_d    = '0;
                ctrl_d  = CTRL_NOP;
                rd1_d   = '0;
                rd2_d   = '0;
                imm_d   = '0;
                pc_d    = '0;
            end else begin
                valid_d = validD;
                rs1_d   = rs1D;
                rs2_d   = rs2D;
                rd_d    = rdD;
                // An invalid Decode slot must not carry side-effecting control.
                ctrl_d  = validD ? ctrlD : CTRL_NOP;
                rd1_d   = rd1D;
                rd2_d   = rd2D;
                imm_d   = immD;
                pc_d    = pcD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of block order.
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= CTRL_NOP;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
        end
    end

    assign validE = valid_q;
    assign rs1E   = rs1_q;
    assign rs2E   = rs2_q;
    assign rdE    = rd_q;
    assign ctrlE  = ctrl_q;
    assign rd1E   = rd1_q;
    assign rd2E   = rd2_q;
    assign immE   = imm_q;
    assign pcE    = pc_q;

    // A taken branch discards the stalled Decode instruction, so the
    // load-use stall is suppressed in favour of the flush.
    assign stallF = stall_mem || (lu && !branch_takenE);
    assign stallD = stallF;
    assign flushD = branch_takenE && !stall_mem;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (lu && !branch_takenE && !stall_mem && (lu_cnt_q != '1))
                lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            if (flushD && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign lu_stall_cnt = lu_cnt_q;
    assign flush_cnt    = flush_cnt_q;
`endif

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed self-checking bench for id_ex_stage. Inputs change 1 ns after the
// rising edge; registered outputs are sampled 1 ns after the edge and
// combinational outputs 1 ns after the inputs change.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    import pipeline_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        validD;
    logic [4:0]  rs1D, rs2D, rdD;
    logic        use_rs1D, use_rs2D;
    ctrl_t       ctrlD;
    logic [31:0] rd1D, rd2D, immD, pcD;
    logic        branch_takenE;
    logic        stall_mem;
    logic        validE;
    logic [4:0]  rs1E, rs2E, rdE;
    ctrl_t       ctrlE;
    logic [31:0] rd1E, rd2E, immE, pcE;
    logic        stallF, stallD, flushD;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] lu_stall_cnt, flush_cnt;
`endif

    int tests = 0;
    int fails = 0;

    localparam ctrl_t C_ADD = '{regwrite: 1'b1, memread: 1'b0, memwrite: 1'b0, branch: 1'b0,
                                jump: 1'b0, alusrc: 1'b0, aluop: ALU_ADD, wbsel: WB_ALU};
    localparam ctrl_t C_LW  = '{regwrite: 1'b1, memread: 1'b1, memwrite: 1'b0, branch: 1'b0,
                                jump: 1'b0, alusrc: 1'b1, aluop: ALU_ADD, wbsel: WB_MEM};
    localparam ctrl_t C_SW  = '{regwrite: 1'b0, memread: 1'b0, memwrite: 1'b1, branch: 1'b0,
                                jump: 1'b0, alusrc: 1'b1, aluop: ALU_ADD, wbsel: WB_ALU};

    id_ex_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .validD        (validD),
        .rs1D          (rs1D),
        .rs2D          (rs2D),
        .rdD           (rdD),
        .use_rs1D      (use_rs1D),
        .use_rs2D      (use_rs2D),
        .ctrlD         (ctrlD),
        .rd1D          (rd1D),
        .rd2D          (rd2D),
        .immD          (immD),
        .pcD           (pcD),
        .branch_takenE (branch_takenE),
        .stall_mem     (stall_mem),
        .validE        (validE),
        .rs1E          (rs1E),
        .rs2E          (rs2E),
        .rdE           (rdE),
        .ctrlE         (ctrlE),
        .rd1E          (rd1E),
        .rd2E          (rd2E),
        .immE          (immE),
        .pcE           (pcE),
        .stallF        (stallF),
        .stallD        (stallD),
        .flushD        (flushD)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .lu_stall_cnt  (lu_stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic u1, input logic u2,
                           input ctrl_t c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] pc);
        validD   = v;
        rs1D     = rs1;
        rs2D     = rs2;
        rdD      = rd;
        use_rs1D = u1;
        use_rs2D = u2;
        ctrlD    = c;
        rd1D     = a;
        rd2D     = b;
        immD     = imm;
        pcD      = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        branch_takenE = 1'b0;
        stall_mem = 1'b0;
        drive_d(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, C_LW, 32'h11, 32'h22, 32'h33, 32'h44);
        #2 rst_n = 1'b0;   // before the first rising edge at t=5
        #1;
        tests++; if (validE !== 1'b0) begin fails++; $display("FAIL reset_validE: got %b exp 0", validE); end
        tests++; if (rdE !== 5'd0) begin fails++; $display("FAIL reset_rdE: got %0d exp 0", rdE); end
        tests++; if (ctrlE !== CTRL_NOP) begin fails++; $display("FAIL reset_ctrlE: got %h exp %h", ctrlE, CTRL_NOP); end
        tests++; if ({stallF, stallD, flushD} !== 3'b000) begin fails++; $display("FAIL reset_hazards: got %b exp 000", {stallF, stallD, flushD}); end
        tick();
        tests++; if (rd1E !== 32'd0) begin fails++; $display("FAIL reset_held_rd1E: got %h exp 0", rd1E); end
        rst_n = 1'b1;
    endtask

    task automatic test_normal_flow();
        // add x3, x1, x2
        drive_d(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, C_ADD, 32'd5, 32'd7, 32'd0, 32'h100);
        tick();
        tests++; if (rdE !== 5'd3) begin fails++; $display("FAIL flow_rdE: got %0d exp 3", rdE); end
        tests++; if (rd1E !== 32'd5) begin fails++; $display("FAIL flow_rd1E: got %0d exp 5", rd1E); end
        tests++; if (rd2E !== 32'd7) begin fails++; $display("FAIL flow_rd2E: got %0d exp 7", rd2E); end
        tests++; if (ctrlE.regwrite !== 1'b1) begin fails++; $display("FAIL flow_regwriteE: got %b exp 1", ctrlE.regwrite); end
        tests++; if (validE !== 1'b1) begin fails++; $display("FAIL flow_validE: got %b exp 1", validE); end
        tests++; if (rs1E !== 5'd1 || rs2E !== 5'd2) begin fails++; $display("FAIL flow_rsE: got %0d/%0d exp 1/2", rs1E, rs2E); end
        tests++; if (pcE !== 32'h100) begin fails++; $display("FAIL flow_pcE: got %h exp 100", pcE); end
        // invalid Decode slot carrying store control must enter EX as NOP
        drive_d(1'b0, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, C_SW, 32'h9, 32'h8, 32'h7, 32'h104);
        tick();
        tests++; if (validE !== 1'b0) begin fails++; $display("FAIL invalid_validE: got %b exp 0", validE); end
        tests++; if (ctrlE !== CTRL_NOP) begin fails++; $display("FAIL invalid_ctrlE: got %h exp %h", ctrlE, CTRL_NOP); end
        tests++; if (immE !== 32'h7) begin fails++; $display("FAIL invalid_immE: got %h exp 7", immE); end
    endtask

    task automatic test_load_use();
        // lw x5, 0(x2)
        drive_d(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 32'h40, 32'h0, 32'h0, 32'h200);
        tick();
        // add x7, x5, x1 depends on the load
        drive_d(1'b1, 5'd5, 5'd1, 5'd7, 1'b1, 1'b1, C_ADD, 32'h11, 32'h22, 32'h0, 32'h204);
        #1;
        tests++; if ({stallF, stallD, flushD} !== 3'b110) begin fails++; $display("FAIL lu_hazards: got %b exp 110", {stallF, stallD, flushD}); end
        tick();
        tests++; if (validE !== 1'b0) begin fails++; $display("FAIL lu_bubble_validE: got %b exp 0", validE); end
        tests++; if (ctrlE !== CTRL_NOP) begin fails++; $display("FAIL lu_bubble_ctrlE: got %h exp %h", ctrlE, CTRL_NOP); end
        tests++; if (rdE !== 5'd0) begin fails++; $display("FAIL lu_bubble_rdE: got %0d exp 0", rdE); end
        tests++; if (stallF !== 1'b0) begin fails++; $display("FAIL lu_release_stallF: got %b exp 0", stallF); end
        tick();
        tests++; if (validE !== 1'b1 || rs1E !== 5'd5 || rdE !== 5'd7) begin fails++; $display("FAIL lu_enter: got v=%b rs1=%0d rd=%0d exp v=1 rs1=5 rd=7", validE, rs1E, rdE); end
    endtask

    task automatic test_x0_unused();
        // lw x0 followed by a reader of x0: no hazard
        drive_d(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, C_LW, 32'h0, 32'h0, 32'h0, 32'h300);
        tick();
        drive_d(1'b1, 5'd0, 5'd1, 5'd8, 1'b1, 1'b1, C_ADD, 32'h0, 32'h0, 32'h0, 32'h304);
        #1;
        tests++; if (stallF !== 1'b0) begin fails++; $display("FAIL x0_stallF: got %b exp 0", stallF); end
        // lw x6, then D names rs2=6 but does not read it
        drive_d(1'b1, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, C_LW, 32'h0, 32'h0, 32'h0, 32'h308);
        tick();
        drive_d(1'b1, 5'd1, 5'd6, 5'd9, 1'b1, 1'b0, C_ADD, 32'h0, 32'h0, 32'h0, 32'h30c);
        #1;
        tests++; if (stallF !== 1'b0) begin fails++; $display("FAIL unused_rs2_stallF: got %b exp 0", stallF); end
        use_rs2D = 1'b1;
        #1;
        tests++; if (stallD !== 1'b1) begin fails++; $display("FAIL used_rs2_stallD: got %b exp 1", stallD); end
        tick();   // bubble
        tick();   // dependent instruction enters EX
    endtask

    task automatic test_branch_load_use();
        drive_d(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 32'h0, 32'h0, 32'h0, 32'h400);
        tick();
        drive_d(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, C_ADD, 32'h0, 32'h0, 32'h0, 32'h404);
        branch_takenE = 1'b1;
        #1;
        tests++; if ({stallF, stallD, flushD} !== 3'b001) begin fails++; $display("FAIL br_lu_hazards: got %b exp 001", {stallF, stallD, flushD}); end
        tick();
        tests++; if (validE !== 1'b0 || ctrlE !== CTRL_NOP) begin fails++; $display("FAIL br_bubble: got v=%b ctrl=%h exp v=0 ctrl=%h", validE, ctrlE, CTRL_NOP); end
        branch_takenE = 1'b0;
        validD = 1'b0;
    endtask

    task automatic test_stall_mem();
        // add x9 into EX
        drive_d(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, C_ADD, 32'hAA, 32'hBB, 32'h0, 32'h500);
        tick();
        drive_d(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b1, C_ADD, 32'hCC, 32'hDD, 32'h0, 32'h504);
        stall_mem = 1'b1;
        branch_takenE = 1'b1;
        #1;
        tests++; if ({stallF, stallD, flushD} !== 3'b110) begin fails++; $display("FAIL mem_hazards: got %b exp 110", {stallF, stallD, flushD}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (validE !== 1'b1 || rdE !== 5'd9 || rd1E !== 32'hAA || pcE !== 32'h500) begin
                fails++; $display("FAIL mem_hold_%0d: got v=%b rd=%0d rd1=%h pc=%h exp v=1 rd=9 rd1=aa pc=500", i, validE, rdE, rd1E, pcE);
            end
        end
        stall_mem = 1'b0;
        branch_takenE = 1'b0;
        #1;
        tests++; if (stallF !== 1'b0) begin fails++; $display("FAIL mem_release_stallF: got %b exp 0", stallF); end
        tick();
        tests++; if (rdE !== 5'd10 || rd2E !== 32'hDD) begin fails++; $display("FAIL mem_advance: got rd=%0d rd2=%h exp rd=10 rd2=dd", rdE, rd2E); end
    endtask

    task automatic test_back_to_back();
        // lw x5 ; lw x6 (independent) ; add x8, x6 -> stall only on the last
        drive_d(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 32'h0, 32'h0, 32'h0, 32'h600);
        tick();
        drive_d(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, C_LW, 32'h0, 32'h0, 32'h0, 32'h604);
        #1;
        tests++; if (stallF !== 1'b0) begin fails++; $display("FAIL b2b_second_load_stallF: got %b exp 0", stallF); end
        tick();
        drive_d(1'b1, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0, C_ADD, 32'h0, 32'h0, 32'h0, 32'h608);
        #1;
        tests++; if (stallF !== 1'b0) begin fails++; $display("FAIL b2b_older_load_stallF: got %b exp 0", stallF); end
        rs1D = 5'd6;
        #1;
        tests++; if (stallF !== 1'b1) begin fails++; $display("FAIL b2b_dep_stallF: got %b exp 1", stallF); end
        tick();
        tests++; if (validE !== 1'b0 || stallF !== 1'b0) begin fails++; $display("FAIL b2b_bubble: got v=%b stall=%b exp v=0 stall=0", validE, stallF); end
        tick();
        tests++; if (rdE !== 5'd8 || validE !== 1'b1) begin fails++; $display("FAIL b2b_enter: got rd=%0d v=%b exp rd=8 v=1", rdE, validE); end
    endtask

    task automatic test_reset_mid_stall();
        drive_d(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 32'h0, 32'h0, 32'h0, 32'h700);
        tick();
        drive_d(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, C_ADD, 32'h0, 32'h0, 32'h0, 32'h704);
        #1;
        tests++; if (stallF !== 1'b1) begin fails++; $display("FAIL rst_pre_stallF: got %b exp 1", stallF); end
        rst_n = 1'b0;
        #1;
        tests++; if (stallF !== 1'b0 || validE !== 1'b0 || rdE !== 5'd0) begin fails++; $display("FAIL rst_async_clear: got stall=%b v=%b rd=%0d exp 0/0/0", stallF, validE, rdE); end
        rst_n = 1'b1;
        #1;
        tests++; if (stallF !== 1'b0) begin fails++; $display("FAIL rst_release_stallF: got %b exp 0", stallF); end
        tick();
        tests++; if (validE !== 1'b1 || rdE !== 5'd7) begin fails++; $display("FAIL rst_after_enter: got v=%b rd=%0d exp v=1 rd=7", validE, rdE); end
    endtask

    initial begin
        test_reset();
        test_normal_flow();
        test_load_use();
        test_x0_unused();
        test_branch_load_use();
        test_stall_mem();
        test_back_to_back();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog: the directed sequence is a few dozen cycles.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running at %0t, limit 20000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_id_ex_stage
